tt_sweep_capture: RTL and testbench
===================================

Name: tt_sweep_capture

Overview:
Sequential truth-table extractor: the driving/reading end of a combinational N-input, 1-output logic function.
- On a start request, drives every input combination 0 .. 2^N_IN-1 onto x_out.
- Waits a programmable settle time per combination, then samples the function's f output.
- Assembles the results into a 2^N_IN-bit truth-table word.
- Sits beside any combinational truth-table module (for example the 3-input f(x3,x2,x1) blocks) for self-characterisation and built-in checking.

Parameters:
N_IN, 3, number of function inputs; x_out width; table width is 2^N_IN.
SETTLE, 1, wait cycles between driving a combination and sampling f_in; legal range 0..15.

Ports:
clk  input  1  single clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  sweep request; sampled only in IDLE.
f_in  input  1  output of the function under test.
x_out  output  N_IN  current input combination; x_out[N_IN-1] = MSB (x3 for N_IN=3), x_out[0] = LSB (x1).
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse when a sweep completes.
table_out  output  2^N_IN  last completed truth table; bit i = f for combination i.

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset values: state=IDLE, x_out=0, busy=0, done=0, table_out=0, internal shadow table=0, idx=0, settle count=0.
- States: IDLE, WAIT, SAMP, FIN.
- IDLE:
  - start=1 at an edge -> x_out=0, idx=0, shadow cleared.
  - Next state is WAIT with count=SETTLE, or SAMP if SETTLE=0.
- WAIT:
  - Count decrements each cycle.
  - On the edge where count=1 -> SAMP.
  - x_out is held stable.
- SAMP (one cycle):
  - At the ending edge, shadow[idx] <= f_in.
  - If idx = 2^N_IN-1 -> FIN, x_out held.
  - Otherwise idx++, x_out++, back to WAIT (count=SETTLE) or SAMP again if SETTLE=0.
- FIN (one cycle):
  - done=1; table_out is loaded from the shadow register (the final sample included) on the same edge that enters FIN.
  - Next edge -> IDLE, done=0, x_out=0.
- Latency:
  - Each combination costs SETTLE+1 cycles.
  - done is high in cycle E0 + 2^N_IN*(SETTLE+1), where E0 is the edge that accepted start.
  - Examples: N_IN=3, SETTLE=1 -> 16 cycles; SETTLE=0 -> 8 cycles.
- busy rises at E0 and falls on the edge leaving FIN, so busy=1 during FIN.
- start while busy (WAIT/SAMP/FIN) is ignored, not queued. A start held high across FIN-to-IDLE begins a new sweep at the first IDLE edge.
- table_out is stable between sweeps and changes only on the edge entering FIN. The previous table remains visible throughout a new sweep.
- idx and x_out wrap only by restart, never by increment past 2^N_IN-1.
- rst mid-sweep: immediate return to reset values, including table_out=0; a partial sweep is discarded; no done pulse.
- rst and start in the same cycle: rst wins.

Optional Feature:
Macro TT_SWEEP_CHECK_EN.
- Defined:
  - Adds input expected_table [2^N_IN], sampled at E0 and held internally.
  - Adds outputs mismatch (1) and mismatch_mask (2^N_IN).
  - Both outputs update on the edge entering FIN: mismatch_mask = shadow XOR held expected, mismatch = OR-reduce(mask).
  - Both hold until the next FIN or reset; reset value is 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
1. rst held 2 cycles, then released with start=0 -> x_out=0, busy=0, done=0, table_out=8'h00 for 10 cycles.
2. Characterisation, N_IN=3, SETTLE=1:
   - Stimulus: f_in = (x3&~x2)|(~x3&~x1) driven from x_out; 1-cycle start.
   - Required response: x_out steps 0..7, each value held 2 cycles; done pulses exactly once, 16 cycles after the start edge; table_out=8'h35; busy low the cycle after done.
3. SETTLE=0 with f_in tied 1 -> done 8 cycles after start; table_out=8'hFF. A second sweep with f_in tied 0 -> table_out=8'h00 and 8'hFF visible until that FIN.
4. start held high 20 cycles, SETTLE=1 -> exactly one sweep in the first 16 cycles; a second sweep begins at the first IDLE edge; no extra done pulses.
5. rst asserted during SAMP of combination 3 -> next cycle: busy=0, x_out=0, table_out=0; no done. A following start completes normally with 8'h35.
6. TT_SWEEP_CHECK_EN defined, expected_table=8'h35, f_in forced to 0 at combination 5 -> mismatch=1, mismatch_mask=8'h20. A rerun with the correct f gives mismatch=0, mask=8'h00.

Source files
------------

// File: rtl/tt_sweep_capture.sv
// Truth-table sweeper: drives every input combination, samples f_in after SETTLE cycles, assembles table_out.
// Optional expected-table comparison is enabled by defining TT_SWEEP_CHECK_EN.
module tt_sweep_capture #(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    f_in,
`ifdef TT_SWEEP_CHECK_EN
    input  logic [(1<<N_IN)-1:0]    expected_table,
    output logic                    mismatch,
    output logic [(1<<N_IN)-1:0]    mismatch_mask,
`endif
    output logic [N_IN-1:0]         x_out,
    output logic                    busy,
    output logic                    done,
    output logic [(1<<N_IN)-1:0]    table_out
);

    localparam int unsigned TW = 1 << N_IN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SAMP,
        S_FIN
    } state_e;

    localparam logic [N_IN-1:0] IDX_LAST   = '1;
    localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);
    // With no settle time each combination goes straight to sampling.
    localparam state_e          FIRST_ST   = (SETTLE == 0) ? S_SAMP : S_WAIT;

    state_e          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [TW-1:0]   shadow_q, shadow_d;
    logic [TW-1:0]   table_q, table_d;
`ifdef TT_SWEEP_CHECK_EN
    logic [TW-1:0]   expected_q, expected_d;
    logic [TW-1:0]   mask_q, mask_d;
    logic            mismatch_q, mismatch_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            shadow_q   <= '0;
            table_q    <= '0;
`ifdef TT_SWEEP_CHECK_EN
            expected_q <= '0;
            mask_q     <= '0;
            mismatch_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            table_q    <= table_d;
`ifdef TT_SWEEP_CHECK_EN
            expected_q <= expected_d;
            mask_q     <= mask_d;
            mismatch_q <= mismatch_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        table_d    = table_q;
`ifdef TT_SWEEP_CHECK_EN
        expected_d = expected_q;
        mask_d     = mask_q;
        mismatch_d = mismatch_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d    = '0;
                    shadow_d = '0;
                    cnt_d    = SETTLE_CNT;
                    state_d  = FIRST_ST;
`ifdef TT_SWEEP_CHECK_EN
                    expected_d = expected_table;
`endif
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_SAMP;
                end
            end
            S_SAMP: begin
                shadow_d[idx_q] = f_in;
                if (idx_q == IDX_LAST) begin
                    // Final sample lands in table_out on the same edge that enters FIN.
                    state_d = S_FIN;
                    table_d = shadow_d;
`ifdef TT_SWEEP_CHECK_EN
                    mask_d     = shadow_d ^ expected_q;
                    mismatch_d = |(shadow_d ^ expected_q);
`endif
                end else begin
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = SETTLE_CNT;
                    state_d = FIRST_ST;
                end
            end
            S_FIN: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_FIN);
        x_out     = idx_q;
        table_out = table_q;
`ifdef TT_SWEEP_CHECK_EN
        mismatch      = mismatch_q;
        mismatch_mask = mask_q;
`endif
    end

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench for tt_sweep_capture: one instance with SETTLE=1, one with SETTLE=0.
module tb_tt_sweep_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0, start0 = 1'b0;
    logic [1:0] fmode1 = 2'd0, fmode0 = 2'd0;
    logic       f1, f0;
    logic [2:0] x1o, x0o;
    logic       busy1, done1, busy0, done0;
    logic [7:0] table1, table0;
`ifdef TT_SWEEP_CHECK_EN
    logic [7:0] exp1 = 8'h35, exp0 = 8'h00;
    logic       mism1, mism0;
    logic [7:0] mask1, mask0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // mode 0: reference function, 1: constant 1, 2: constant 0, 3: reference with combination 5 forced 0
    function automatic logic fmodel(input logic [1:0] m, input logic [2:0] x);
        logic r;
        r = (x[2] & ~x[1]) | (~x[2] & ~x[0]);
        case (m)
            2'd1:    return 1'b1;
            2'd2:    return 1'b0;
            2'd3:    return (x == 3'd5) ? 1'b0 : r;
            default: return r;
        endcase
    endfunction

    assign f1 = fmodel(fmode1, x1o);
    assign f0 = fmodel(fmode0, x0o);

    tt_sweep_capture #(.N_IN(3), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start1), .f_in(f1),
`ifdef TT_SWEEP_CHECK_EN
        .expected_table(exp1), .mismatch(mism1), .mismatch_mask(mask1),
`endif
        .x_out(x1o), .busy(busy1), .done(done1), .table_out(table1)
    );

    tt_sweep_capture #(.N_IN(3), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .f_in(f0),
`ifdef TT_SWEEP_CHECK_EN
        .expected_table(exp0), .mismatch(mism0), .mismatch_mask(mask0),
`endif
        .x_out(x0o), .busy(busy0), .done(done0), .table_out(table0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Packed view {x_out, busy, done, table_out}
    function automatic logic [31:0] pk(input logic [2:0] x, input logic b, input logic d, input logic [7:0] t);
        return 32'({x, b, d, t});
    endfunction

    task automatic sweep1(input string tag, input logic [7:0] exp_t, input logic [7:0] prev_t);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int j = 0; j < 16; j++) begin
            check_eq({tag, "_step"}, pk(x1o, busy1, done1, table1), pk(3'(j / 2), 1'b1, 1'b0, prev_t));
            tick();
        end
        check_eq({tag, "_fin"}, pk(x1o, busy1, done1, table1), pk(3'd7, 1'b1, 1'b1, exp_t));
        tick();
        check_eq({tag, "_idle"}, pk(x1o, busy1, done1, table1), pk(3'd0, 1'b0, 1'b0, exp_t));
    endtask

    task automatic sweep0(input string tag, input logic [7:0] exp_t, input logic [7:0] prev_t);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int j = 0; j < 8; j++) begin
            check_eq({tag, "_step"}, pk(x0o, busy0, done0, table0), pk(3'(j), 1'b1, 1'b0, prev_t));
            tick();
        end
        check_eq({tag, "_fin"}, pk(x0o, busy0, done0, table0), pk(3'd7, 1'b1, 1'b1, exp_t));
        tick();
        check_eq({tag, "_idle"}, pk(x0o, busy0, done0, table0), pk(3'd0, 1'b0, 1'b0, exp_t));
    endtask

    initial begin
        int dones;

        // 1: reset and quiet idle
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            check_eq("rst_idle1", pk(x1o, busy1, done1, table1), 32'd0);
            check_eq("rst_idle0", pk(x0o, busy0, done0, table0), 32'd0);
        end

        // 2: characterisation with SETTLE=1
        fmode1 = 2'd0;
        sweep1("char", 8'h35, 8'h00);

        // 3: SETTLE=0, constant functions
        fmode0 = 2'd1;
        sweep0("s0_ones", 8'hFF, 8'h00);
        fmode0 = 2'd2;
        sweep0("s0_zeros", 8'h00, 8'hFF);
`ifdef TT_SWEEP_CHECK_EN
        check_eq("s0_mismatch", 32'({mism0, mask0}), 32'd0);
`endif

        // 4: start held high for 20 edges
        dones  = 0;
        start1 = 1'b1;
        tick();
        for (int j = 0; j <= 40; j++) begin
            if (j == 19) start1 = 1'b0;
            if (done1) dones++;
            check_eq("hold_done", 32'(done1), 32'((j == 16) || (j == 34)));
            if (j == 17) check_eq("hold_gap", pk(x1o, busy1, done1, table1), pk(3'd0, 1'b0, 1'b0, 8'h35));
            if (j == 18) check_eq("hold_restart", pk(x1o, busy1, done1, table1), pk(3'd0, 1'b1, 1'b0, 8'h35));
            if (j == 20) check_eq("hold_second_x", 32'(x1o), 32'd1);
            tick();
        end
        check_eq("hold_done_count", 32'(dones), 32'd2);
        check_eq("hold_end", pk(x1o, busy1, done1, table1), pk(3'd0, 1'b0, 1'b0, 8'h35));

        // 5: reset during SAMP of combination 3
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (7) tick();
        check_eq("mid_pre", pk(x1o, busy1, done1, table1), pk(3'd3, 1'b1, 1'b0, 8'h35));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst", pk(x1o, busy1, done1, table1), 32'd0);
        dones = 0;
        repeat (20) begin
            tick();
            if (done1 || busy1) dones++;
        end
        check_eq("mid_quiet", 32'(dones), 32'd0);
        sweep1("after_rst", 8'h35, 8'h00);

`ifdef TT_SWEEP_CHECK_EN
        // 6: expected-table comparison
        check_eq("chk_clean0", 32'({mism1, mask1}), 32'd0);
        exp1   = 8'h35;
        fmode1 = 2'd3;
        sweep1("chk_bad", 8'h15, 8'h35);
        check_eq("chk_bad_mism", 32'({mism1, mask1}), 32'({1'b1, 8'h20}));
        fmode1 = 2'd0;
        sweep1("chk_good", 8'h35, 8'h15);
        check_eq("chk_good_mism", 32'({mism1, mask1}), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
